interface_ov7670_uc: RTL
========================

Name: interface_OV7670_uc

Overview:
- Control unit for the OV7670 capture datapath; sequences one frame grab per `iniciar` request.
- On command it:
  - waits for frame start;
  - assembles each 16-bit pixel from two PCLK bytes;
  - walks the pixel line/column counters;
  - writes the 9 sampled quadrant pixels into the 3x3 RAM through the quadrant counters.
- Sits beside the datapath in the capture top level; reports `pronto` or `erro` to the robot's main controller.

Parameters:
- LINES, 120, pixel lines per frame; must match the datapath.
- COLUMNS, 320, pixels per line; must match the datapath.
- S_LINE, 7, width of the internal line counter.
- S_COLUMN, 9, width of the internal column counter.
- QUADS, 9, quadrant samples expected per frame.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  one-cycle capture request.
- transmite_frame  in  1  frame-start pulse from the datapath.
- transmite_byte  in  1  PCLK rising-edge pulse from the datapath.
- escreve_byte  in  1  current pixel coordinate is a quadrant sample point.
- fim_coluna_quadrante  in  1  quadrant column counter at its last value (2).
- byte_estavel  out  1  load D into the pixel register.
- we_byte  out  1  RAM write strobe.
- zera_linha_pixel, zera_coluna_pixel  out  1 each  clear the pixel counters.
- conta_linha_pixel, conta_coluna_pixel  out  1 each  increment the pixel counters.
- zera_linha_quadrante, zera_coluna_quadrante  out  1 each  clear the quadrant counters.
- conta_linha_quadrante, conta_coluna_quadrante  out  1 each  increment the quadrant counters.
- ocupado  out  1  capture in progress.
- pronto  out  1  one-cycle pulse: 9 pixels stored.
- erro  out  1  sticky: last capture ended abnormally.
- db_estado  out  4  current state encoding, for debug.

Behaviour:
- Reset (reset=0, async): state INICIAL, internal counters 0, erro=0. All outputs 0 except the four zera_* outputs, which are 1.
- All outputs are Moore or registered. Each strobe is exactly one clock wide.
- FSM states and transitions:
  - INICIAL(0): pulse all zera_*, then go to OCIOSO.
  - OCIOSO(1): on iniciar go to ESPERA_FRAME and clear erro. iniciar in any other state is ignored.
  - ESPERA_FRAME(2): on transmite_frame, pulse all zera_*, clear internal counters, go to ESPERA_ALTO. ocupado=1 from here through FIM.
  - ESPERA_ALTO(3): on transmite_byte go to CAPTURA_ALTO.
  - CAPTURA_ALTO(4): byte_estavel=1 for one clock, then go to ESPERA_BAIXO.
  - ESPERA_BAIXO(5): on transmite_byte go to CAPTURA_BAIXO.
  - CAPTURA_BAIXO(6): byte_estavel=1, then go to AVALIA.
  - AVALIA(7): sample escreve_byte. If 1 go to GRAVA, else go to AVANCA.
  - GRAVA(8): we_byte=1 and conta_coluna_quadrante=1; quadrant write count +1.
    - If fim_coluna_quadrante=1: also conta_linha_quadrante=1 and zera_coluna_quadrante=1.
    - Then go to AVANCA.
  - AVANCA(9): advance the pixel position, then choose the next state.
    - Column < COLUMNS-1: conta_coluna_pixel=1.
    - Column = COLUMNS-1: zera_coluna_pixel=1 and conta_linha_pixel=1.
    - Internal column/line counters mirror these actions.
    - Write count = QUADS: go to FIM.
    - Else if last column of last line: go to FIM with erro=1 (frame ended short).
    - Else go to ESPERA_ALTO.
  - FIM(10): pronto=1 if erro=0, then go to OCIOSO.
- Byte pairing:
  - The first byte after the frame pulse is the high byte.
  - The pixel register shifts on each byte_estavel.
  - we_byte fires only after both bytes are loaded, so RAM data is the complete 16-bit pixel.
- Timing: escreve_byte is evaluated in AVALIA, before the pixel counters move. Counter increments land one clock after AVANCA.
- transmite_frame while in states 3–9 (frame restarted mid-capture):
  - pulse all zera_* and restart at ESPERA_ALTO;
  - write count returns to 0;
  - erro is not set.
- A transmite_byte arriving in a non-waiting state (4, 6–9) is dropped; at the 50 MHz system clock vs. the 1 MHz XCLK this cannot occur.
- Boundaries:
  - Counter wrap happens only through the zera_* outputs; the controller never lets a datapath counter roll over by itself.
  - Reset mid-capture returns to INICIAL immediately; a partial RAM contents is acceptable.

Optional Feature:
- Macro: OV7670_TIMEOUT_EN.
- When defined:
  - a 20-bit watchdog clears on every transmite_byte and transmite_frame, and counts while in states 2, 3 and 5;
  - when it reaches 2^20-1 (~21 ms), the FSM goes to FIM with erro=1 and pronto stays 0.
- When undefined: no watchdog; the FSM waits indefinitely. Port list is identical in both builds.

Test Plan:
- Reset then release -> all zera_*=1 for one clock in INICIAL, then state OCIOSO. ocupado=0, pronto=0, erro=0.
- iniciar, frame pulse, 120x320 pixels of 2 bytes each, escreve_byte asserted at (19,79), (19,159), ..., (99,239):
  - exactly 9 we_byte pulses;
  - quadrant addresses visited in order (0,0)..(2,2);
  - pronto pulses once after the 9th write;
  - erro=0.
- Bytes 0xAB then 0xCD at sample point (19,79) -> RAM[0][0]=0xABCD. we_byte occurs 2 clocks after the second byte_estavel.
- Frame with escreve_byte held 0 -> zero writes; at column 319 of line 119, FIM is reached with erro=1 and no pronto.
- transmite_frame injected after 4 writes -> quadrant counters cleared; the subsequent full frame yields 9 writes and pronto.
- With OV7670_TIMEOUT_EN: iniciar with no frame pulse -> after 2^20-1 clocks erro=1, state returns to OCIOSO, no pronto. Without the macro, state remains ESPERA_FRAME.

Source files
------------

// File: rtl/interface_ov7670_uc.sv
// Control unit for the OV7670 capture datapath: one frame grab per iniciar request.
// Optional watchdog on the waiting states is enabled with OV7670_TIMEOUT_EN.
`timescale 1ns/1ps
module interface_ov7670_uc #(
    parameter int unsigned LINES    = 120,
    parameter int unsigned COLUMNS  = 320,
    parameter int unsigned S_LINE   = 7,
    parameter int unsigned S_COLUMN = 9,
    parameter int unsigned QUADS    = 9
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       iniciar_i,
    input  logic       transmite_frame_i,
    input  logic       transmite_byte_i,
    input  logic       escreve_byte_i,
    input  logic       fim_coluna_quadrante_i,
    output logic       byte_estavel_o,
    output logic       we_byte_o,
    output logic       zera_linha_pixel_o,
    output logic       zera_coluna_pixel_o,
    output logic       conta_linha_pixel_o,
    output logic       conta_coluna_pixel_o,
    output logic       zera_linha_quadrante_o,
    output logic       zera_coluna_quadrante_o,
    output logic       conta_linha_quadrante_o,
    output logic       conta_coluna_quadrante_o,
    output logic       ocupado_o,
    output logic       pronto_o,
    output logic       erro_o,
    output logic [3:0] db_estado_o
);

    localparam int unsigned QW = $clog2(QUADS + 1);
    localparam logic [S_COLUMN-1:0] ColLast = S_COLUMN'(COLUMNS - 1);
    localparam logic [S_LINE-1:0]   LineLast = S_LINE'(LINES - 1);
    localparam logic [QW-1:0]       QuadsVal = QW'(QUADS);

    typedef enum logic [3:0] {
        StInicial      = 4'd0,
        StOcioso       = 4'd1,
        StEsperaFrame  = 4'd2,
        StEsperaAlto   = 4'd3,
        StCapturaAlto  = 4'd4,
        StEsperaBaixo  = 4'd5,
        StCapturaBaixo = 4'd6,
        StAvalia       = 4'd7,
        StGrava        = 4'd8,
        StAvanca       = 4'd9,
        StFim          = 4'd10
    } state_e;

    state_e              state_q;
    logic [S_LINE-1:0]   line_q;
    logic [S_COLUMN-1:0] col_q;
    logic [QW-1:0]       nwr_q;
    logic                erro_q, pronto_q, byte_estavel_q, we_byte_q;
    logic                zera_lp_q, zera_cp_q, conta_lp_q, conta_cp_q;
    logic                zera_lq_q, zera_cq_q, conta_lq_q, conta_cq_q;
    logic                col_last, frame_restart, wd_expired;

    assign col_last      = (col_q == ColLast);
    assign frame_restart = transmite_frame_i && (state_q >= StEsperaFrame) &&
                           (state_q <= StAvanca);

`ifdef OV7670_TIMEOUT_EN
    logic [19:0] wd_q;
    logic        waiting;

    assign waiting    = (state_q == StEsperaFrame) || (state_q == StEsperaAlto) ||
                        (state_q == StEsperaBaixo);
    assign wd_expired = waiting && (wd_q == '1);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wd_q <= '0;
        end else if (transmite_frame_i || transmite_byte_i || !waiting) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // Strobes are registered on the transition into the state they belong to.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q        <= StInicial;
            line_q         <= '0;
            col_q          <= '0;
            nwr_q          <= '0;
            erro_q         <= 1'b0;
            pronto_q       <= 1'b0;
            byte_estavel_q <= 1'b0;
            we_byte_q      <= 1'b0;
            zera_lp_q      <= 1'b1;
            zera_cp_q      <= 1'b1;
            zera_lq_q      <= 1'b1;
            zera_cq_q      <= 1'b1;
            conta_lp_q     <= 1'b0;
            conta_cp_q     <= 1'b0;
            conta_lq_q     <= 1'b0;
            conta_cq_q     <= 1'b0;
        end else begin
            pronto_q       <= 1'b0;
            byte_estavel_q <= 1'b0;
            we_byte_q      <= 1'b0;
            zera_lp_q      <= 1'b0;
            zera_cp_q      <= 1'b0;
            zera_lq_q      <= 1'b0;
            zera_cq_q      <= 1'b0;
            conta_lp_q     <= 1'b0;
            conta_cp_q     <= 1'b0;
            conta_lq_q     <= 1'b0;
            conta_cq_q     <= 1'b0;
            if (frame_restart) begin
                state_q   <= StEsperaAlto;
                line_q    <= '0;
                col_q     <= '0;
                nwr_q     <= '0;
                zera_lp_q <= 1'b1;
                zera_cp_q <= 1'b1;
                zera_lq_q <= 1'b1;
                zera_cq_q <= 1'b1;
            end else if (wd_expired) begin
                state_q <= StFim;
                erro_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    StInicial: state_q <= StOcioso;
                    StOcioso: begin
                        if (iniciar_i) begin
                            state_q <= StEsperaFrame;
                            erro_q  <= 1'b0;
                        end
                    end
                    StEsperaFrame: state_q <= StEsperaFrame;
                    StEsperaAlto: begin
                        if (transmite_byte_i) begin
                            state_q        <= StCapturaAlto;
                            byte_estavel_q <= 1'b1;
                        end
                    end
                    StCapturaAlto: state_q <= StEsperaBaixo;
                    StEsperaBaixo: begin
                        if (transmite_byte_i) begin
                            state_q        <= StCapturaBaixo;
                            byte_estavel_q <= 1'b1;
                        end
                    end
                    StCapturaBaixo: state_q <= StAvalia;
                    StAvalia: begin
                        if (escreve_byte_i) begin
                            state_q    <= StGrava;
                            we_byte_q  <= 1'b1;
                            conta_cq_q <= 1'b1;
                            if (fim_coluna_quadrante_i) begin
                                conta_lq_q <= 1'b1;
                                zera_cq_q  <= 1'b1;
                            end
                        end else begin
                            state_q    <= StAvanca;
                            conta_cp_q <= !col_last;
                            zera_cp_q  <= col_last;
                            conta_lp_q <= col_last;
                        end
                    end
                    StGrava: begin
                        nwr_q      <= nwr_q + 1'b1;
                        state_q    <= StAvanca;
                        conta_cp_q <= !col_last;
                        zera_cp_q  <= col_last;
                        conta_lp_q <= col_last;
                    end
                    StAvanca: begin
                        if (col_last) begin
                            col_q  <= '0;
                            line_q <= line_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (nwr_q == QuadsVal) begin
                            state_q  <= StFim;
                            pronto_q <= !erro_q;
                        end else if (col_last && (line_q == LineLast)) begin
                            state_q <= StFim;
                            erro_q  <= 1'b1;
                        end else begin
                            state_q <= StEsperaAlto;
                        end
                    end
                    StFim: state_q <= StOcioso;
                    default: state_q <= StInicial;
                endcase
            end
        end
    end

    assign byte_estavel_o           = byte_estavel_q;
    assign we_byte_o                = we_byte_q;
    assign zera_linha_pixel_o       = zera_lp_q;
    assign zera_coluna_pixel_o      = zera_cp_q;
    assign conta_linha_pixel_o      = conta_lp_q;
    assign conta_coluna_pixel_o     = conta_cp_q;
    assign zera_linha_quadrante_o   = zera_lq_q;
    assign zera_coluna_quadrante_o  = zera_cq_q;
    assign conta_linha_quadrante_o  = conta_lq_q;
    assign conta_coluna_quadrante_o = conta_cq_q;
    assign ocupado_o                = (state_q >= StEsperaFrame) && (state_q <= StFim);
    assign pronto_o                 = pronto_q;
    assign erro_o                   = erro_q;
    assign db_estado_o              = state_q;

endmodule
